// File: rtl/sram_bus_pkg.sv
// Shared types and strobe levels for the SRAM bus master.
package sram_bus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTurn,
    StSetup,
    StStrobe,
    StHold
  } sram_state_t;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/sram_bus_master.sv
// Synchronous initiator for an async single-port SRAM: one request at a time, programmable
// setup/strobe lengths. Define SRAM_MASTER_TURNAROUND_EN to insert a TURN cycle on direction change.
module sram_bus_master
  import sram_bus_pkg::*;
#(
  parameter int unsigned AddrWidth    = 11,
  parameter int unsigned DataWidth    = 8,
  parameter int unsigned SetupCycles  = 1,
  parameter int unsigned StrobeCycles = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  output logic [DataWidth-1:0] rsp_rdata_o,
  output logic [AddrWidth-1:0] address_o,
  inout  wire  [DataWidth-1:0] data_io,
  output logic                 csn_o,
  output logic                 wen_o,
  output logic                 oen_o
);

  localparam int unsigned MaxCycles = (SetupCycles > StrobeCycles) ? SetupCycles : StrobeCycles;
  localparam int unsigned CntWidth  = $clog2(MaxCycles + 1);
  localparam logic [CntWidth-1:0] SetupLoad  = CntWidth'(SetupCycles - 1);
  localparam logic [CntWidth-1:0] StrobeLoad = CntWidth'(StrobeCycles - 1);
  localparam logic [CntWidth-1:0] CntOne     = CntWidth'(1);

  sram_state_t          state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [DataWidth-1:0] rdata_q;
  logic [DataWidth-1:0] rsp_rdata_q;
  logic                 write_q;
  logic                 rsp_valid_q;
  logic                 drive_en;
  logic                 accept;
`ifdef SRAM_MASTER_TURNAROUND_EN
  logic                 last_write_q;
`endif

  assign accept = (state_q == StIdle) && req_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
`ifdef SRAM_MASTER_TURNAROUND_EN
          if (req_write_i != last_write_q) begin
            state_d = StTurn;
          end else begin
            state_d = StSetup;
            cnt_d   = SetupLoad;
          end
`else
          state_d = StSetup;
          cnt_d   = SetupLoad;
`endif
        end
      end
      StTurn: begin
        state_d = StSetup;
        cnt_d   = SetupLoad;
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StStrobe;
          cnt_d   = StrobeLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    csn_o    = STROBE_OFF;
    wen_o    = STROBE_OFF;
    oen_o    = STROBE_OFF;
    drive_en = 1'b0;
    unique case (state_q)
      StSetup: begin
        csn_o    = STROBE_ON;
        drive_en = write_q;
      end
      StStrobe: begin
        csn_o    = STROBE_ON;
        wen_o    = write_q ? STROBE_ON : STROBE_OFF;
        oen_o    = write_q ? STROBE_OFF : STROBE_ON;
        drive_en = write_q;
      end
      StHold: begin
        csn_o    = STROBE_ON;
        drive_en = write_q;
      end
      default: ;
    endcase
  end

  // Request capture, read sampling and the response pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        write_q <= req_write_i;
      end
      if (state_q == StStrobe && cnt_q == '0 && !write_q) begin
        rdata_q <= data_io;
      end
      rsp_valid_q <= (state_q == StHold);
      if (state_q == StHold) begin
        rsp_rdata_q <= write_q ? '0 : rdata_q;
      end
    end
  end

`ifdef SRAM_MASTER_TURNAROUND_EN
  // Direction of the last completed access; reset counts as a read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_write_q <= 1'b0;
    end else if (state_q == StHold) begin
      last_write_q <= write_q;
    end
  end
`endif

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign address_o   = addr_q;
  assign data_io     = drive_en ? wdata_q : 'z;

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) !(wen_o == STROBE_ON && oen_o == STROBE_ON));
  assert property (@(posedge clk_i) !(drive_en && oen_o == STROBE_ON));
`endif

endmodule

// File: tb/tb_sram_bus_master.sv
// Directed self-checking bench for sram_bus_master with a behavioural SRAM on the data bus.
module tb_sram_bus_master;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [10:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [10:0] address;
  wire  [7:0]  data;
  logic        csn, wen, oen;

  logic        req_valid2, req_ready2, req_write2;
  logic [10:0] req_addr2;
  logic [7:0]  req_wdata2;
  logic        rsp_valid2;
  logic [7:0]  rsp_rdata2;
  logic [10:0] address2;
  wire  [7:0]  data2;
  logic        csn2, wen2, oen2;

  logic [7:0]  mem [0:2047];
  logic        probe_en;
  logic [7:0]  probe_val;
  int          n_checks, n_pass, viol;

  sram_bus_master u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .address_o(address), .data_io(data),
    .csn_o(csn), .wen_o(wen), .oen_o(oen)
  );

  sram_bus_master #(.SetupCycles(3), .StrobeCycles(1)) u_dut_slow (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid2), .req_ready_o(req_ready2), .req_write_i(req_write2),
    .req_addr_i(req_addr2), .req_wdata_i(req_wdata2),
    .rsp_valid_o(rsp_valid2), .rsp_rdata_o(rsp_rdata2),
    .address_o(address2), .data_io(data2),
    .csn_o(csn2), .wen_o(wen2), .oen_o(oen2)
  );

  // SRAM drives during reads; otherwise an optional probe pattern exposes any master drive.
  assign data  = (!csn && !oen) ? mem[address] : (probe_en ? probe_val : 8'hzz);
  assign data2 = (!csn2 && !oen2) ? 8'h96 : 8'hzz;

  always @(posedge clk) if (!csn && !wen) mem[address] <= data;

  always @(negedge clk) begin
    if (!wen && !oen) viol++;
    if (!wen2 && !oen2) viol++;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    probe_en = 1'b1; probe_val = 8'h3C;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready); else n_pass++;
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_rdata !== 8'h00) $display("FAIL reset_rsp_rdata: got %h expected 00", rsp_rdata); else n_pass++;
    n_checks++; if (address !== 11'h000) $display("FAIL reset_address: got %h expected 000", address); else n_pass++;
    n_checks++; if ({csn, wen, oen} !== 3'b111) $display("FAIL reset_strobes: got %b expected 111", {csn, wen, oen}); else n_pass++;
    n_checks++; if (data !== 8'h3C) $display("FAIL reset_data_hiz: got %h expected 3c", data); else n_pass++;
    rst = 1'b0; probe_en = 1'b0;
    tick();
  endtask

  task automatic test_write();
    logic [4:0] csn_t, wen_t, oen_t, rsp_t, rdy_t, dat_t, adr_t;
    logic [7:0] rdata_last;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 11'h123; req_wdata = 8'hA5;
    tick();
    req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    for (int k = 0; k < 5; k++) begin
      csn_t[k] = csn; wen_t[k] = wen; oen_t[k] = oen;
      rsp_t[k] = rsp_valid; rdy_t[k] = req_ready;
      dat_t[k] = (data === 8'hA5);
      adr_t[k] = (address === 11'h123);
      rdata_last = rsp_rdata;
      tick();
    end
    n_checks++; if (csn_t !== 5'b10000) $display("FAIL write_csn: got %b expected 10000", csn_t); else n_pass++;
    n_checks++; if (wen_t !== 5'b11001) $display("FAIL write_wen: got %b expected 11001", wen_t); else n_pass++;
    n_checks++; if (oen_t !== 5'b11111) $display("FAIL write_oen: got %b expected 11111", oen_t); else n_pass++;
    n_checks++; if (rsp_t !== 5'b10000) $display("FAIL write_rsp_valid: got %b expected 10000", rsp_t); else n_pass++;
    n_checks++; if (rdy_t !== 5'b10000) $display("FAIL write_ready: got %b expected 10000", rdy_t); else n_pass++;
    n_checks++; if (dat_t[3:0] !== 4'hF) $display("FAIL write_data_driven: got %b expected 1111", dat_t[3:0]); else n_pass++;
    n_checks++; if (adr_t !== 5'b11111) $display("FAIL write_address: got %b expected 11111", adr_t); else n_pass++;
    n_checks++; if (rdata_last !== 8'h00) $display("FAIL write_rsp_rdata: got %h expected 00", rdata_last); else n_pass++;
    n_checks++; if (mem[11'h123] !== 8'hA5) $display("FAIL write_mem: got %h expected a5", mem[11'h123]); else n_pass++;
  endtask

  task automatic test_read();
    logic [4:0] csn_t, wen_t, oen_t, rsp_t, dat_t;
    logic [7:0] exp_d;
    logic [7:0] rdata_last;
    probe_en = 1'b1; probe_val = 8'h5A;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 11'h123; req_wdata = 8'hFF;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      csn_t[k] = csn; wen_t[k] = wen; oen_t[k] = oen; rsp_t[k] = rsp_valid;
      exp_d = (k == 1 || k == 2) ? 8'hA5 : 8'h5A;
      dat_t[k] = (data === exp_d);
      rdata_last = rsp_rdata;
      tick();
    end
    probe_en = 1'b0;
    n_checks++; if (csn_t !== 5'b10000) $display("FAIL read_csn: got %b expected 10000", csn_t); else n_pass++;
    n_checks++; if (oen_t !== 5'b11001) $display("FAIL read_oen: got %b expected 11001", oen_t); else n_pass++;
    n_checks++; if (wen_t !== 5'b11111) $display("FAIL read_wen: got %b expected 11111", wen_t); else n_pass++;
    n_checks++; if (rsp_t !== 5'b10000) $display("FAIL read_rsp_valid: got %b expected 10000", rsp_t); else n_pass++;
    n_checks++; if (dat_t !== 5'b11111) $display("FAIL read_bus_hiz: got %b expected 11111", dat_t); else n_pass++;
    n_checks++; if (rdata_last !== 8'hA5) $display("FAIL read_rsp_rdata: got %h expected a5", rdata_last); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc [2];
    int n_acc = 0;
    int csn_hi = 0;
    int n_rsp = 0;
    logic accept_now;
    acc[0] = -100; acc[1] = 100;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 11'h000; req_wdata = 8'h11;
    for (int c = 0; c < 16; c++) begin
      if (n_acc == 1 && csn) csn_hi++;
      if (rsp_valid) n_rsp++;
      accept_now = req_valid && req_ready;
      tick();
      if (accept_now) begin
        acc[n_acc] = c;
        n_acc++;
        if (n_acc == 1) begin
          req_addr = 11'h7FF; req_wdata = 8'h22;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    n_checks++; if (acc[1] - acc[0] !== 5) $display("FAIL b2b_accept_spacing: got %0d expected 5", acc[1] - acc[0]); else n_pass++;
    n_checks++; if (csn_hi !== 1) $display("FAIL b2b_csn_high_gap: got %0d expected 1", csn_hi); else n_pass++;
    n_checks++; if (n_rsp !== 2) $display("FAIL b2b_rsp_count: got %0d expected 2", n_rsp); else n_pass++;
    n_checks++; if (mem[11'h000] !== 8'h11) $display("FAIL b2b_mem0: got %h expected 11", mem[11'h000]); else n_pass++;
    n_checks++; if (mem[11'h7FF] !== 8'h22) $display("FAIL b2b_mem7ff: got %h expected 22", mem[11'h7FF]); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    logic seen_rsp = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 11'h055; req_wdata = 8'hC3;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    n_checks++; if (wen !== 1'b0) $display("FAIL midrst_in_strobe: got wen=%b expected 0", wen); else n_pass++;
    rst = 1'b1;
    tick();
    probe_en = 1'b1; probe_val = 8'h3C;
    #1;
    n_checks++; if ({csn, wen, oen} !== 3'b111) $display("FAIL midrst_strobes: got %b expected 111", {csn, wen, oen}); else n_pass++;
    n_checks++; if (data !== 8'h3C) $display("FAIL midrst_data_hiz: got %h expected 3c", data); else n_pass++;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", req_ready); else n_pass++;
    rst = 1'b0; probe_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid) seen_rsp = 1'b1;
      tick();
    end
    n_checks++; if (seen_rsp !== 1'b0) $display("FAIL midrst_no_rsp: got %b expected 0", seen_rsp); else n_pass++;
  endtask

  // Accept-to-response latency in cycles; -1 if no response within the bound.
  task automatic do_access(input logic wr, input logic [10:0] a, input logic [7:0] d,
                           output int lat, output logic [7:0] rd);
    lat = -1;
    rd  = '0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) begin
        lat = k;
        rd  = rsp_rdata;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_turnaround();
    int lat_w, lat_r1, lat_r2, exp_w, exp_r1, exp_r2;
    logic [7:0] rd0, rd1, rd2;
`ifdef SRAM_MASTER_TURNAROUND_EN
    exp_w = 5; exp_r1 = 5; exp_r2 = 4;
`else
    exp_w = 4; exp_r1 = 4; exp_r2 = 4;
`endif
    do_access(1'b1, 11'h010, 8'h77, lat_w, rd0);
    do_access(1'b0, 11'h010, 8'h00, lat_r1, rd1);
    do_access(1'b0, 11'h010, 8'h00, lat_r2, rd2);
    n_checks++; if (lat_w !== exp_w) $display("FAIL lat_write: got %0d expected %0d", lat_w, exp_w); else n_pass++;
    n_checks++; if (lat_r1 !== exp_r1) $display("FAIL lat_read_after_write: got %0d expected %0d", lat_r1, exp_r1); else n_pass++;
    n_checks++; if (lat_r2 !== exp_r2) $display("FAIL lat_read_after_read: got %0d expected %0d", lat_r2, exp_r2); else n_pass++;
    n_checks++; if (rd1 !== 8'h77) $display("FAIL lat_read1_data: got %h expected 77", rd1); else n_pass++;
    n_checks++; if (rd2 !== 8'h77) $display("FAIL lat_read2_data: got %h expected 77", rd2); else n_pass++;
  endtask

  task automatic test_slow_timing();
    logic [5:0] csn_t, oen_t, rsp_t;
    logic [7:0] rdata_last;
    logic [10:0] addr_k0;
    req_valid2 = 1'b1; req_write2 = 1'b0; req_addr2 = 11'h2AA; req_wdata2 = 8'h00;
    tick();
    req_valid2 = 1'b0;
    addr_k0 = address2;
    for (int k = 0; k < 6; k++) begin
      csn_t[k] = csn2; oen_t[k] = oen2; rsp_t[k] = rsp_valid2;
      rdata_last = rsp_rdata2;
      tick();
    end
    n_checks++; if (csn_t !== 6'b100000) $display("FAIL slow_csn: got %b expected 100000", csn_t); else n_pass++;
    n_checks++; if (oen_t !== 6'b110111) $display("FAIL slow_oen: got %b expected 110111", oen_t); else n_pass++;
    n_checks++; if (rsp_t !== 6'b100000) $display("FAIL slow_rsp_valid: got %b expected 100000", rsp_t); else n_pass++;
    n_checks++; if (rdata_last !== 8'h96) $display("FAIL slow_rsp_rdata: got %h expected 96", rdata_last); else n_pass++;
    n_checks++; if (addr_k0 !== 11'h2AA) $display("FAIL slow_address: got %h expected 2aa", addr_k0); else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; viol = 0;
    rst = 1'b1; probe_en = 1'b0; probe_val = 8'h00;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_valid2 = 1'b0; req_write2 = 1'b0; req_addr2 = '0; req_wdata2 = '0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid_access();
    test_turnaround();
    test_slow_timing();
    n_checks++; if (viol !== 0) $display("FAIL wen_oen_exclusive: got %0d overlaps expected 0", viol); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_bus_master.md
# sram_bus_master

Synchronous initiator for the asynchronous single-port SRAM chip interface: active-low chip select, write enable and output enable, plus a shared bidirectional data bus. It accepts one read or write request at a time from a valid/ready system port. It sequences the SRAM strobes over programmable setup and strobe cycle counts, then returns read data with a one-cycle response pulse. It sits between a CPU/PPU bus front end and the work/video RAM instance.

## Interface
- `addr_width`, 11, SRAM address width
- `data_width`, 8, SRAM data width
- `setup_cycles`, 1, cycles with address/csn stable before the strobe (≥1)
- `strobe_cycles`, 2, cycles wen or oen is held low (≥1)
- `clk`  in  1  system clock; everything is on the rising edge
- `rst`  in  1  reset; synchronous and active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  block can accept; high only in IDLE
- `req_write`  in  1  1 = write, 0 = read
- `req_addr`  in  addr_width  target address
- `req_wdata`  in  data_width  write data
- `rsp_valid`  out  1  one-cycle pulse; the access has completed (reads and writes)
- `rsp_rdata`  out  data_width  read data; valid with `rsp_valid` for reads, 0 for writes
- `address`  out  addr_width  SRAM address
- `data`  inout  data_width  SRAM data bus
- `csn`, `wen`, `oen`  out  1 each  SRAM strobes, active low

## Operation
- States: IDLE, TURN (only when `SRAM_MASTER_TURNAROUND_EN` is defined), SETUP, STROBE, HOLD.
- Acceptance: a request is accepted on an edge where `req_valid && req_ready`. `req_addr`, `req_write` and `req_wdata` are captured into internal registers. Inputs are ignored at all other times.
- IDLE: `csn`=`wen`=`oen`=1. `data` is high-Z. `address` holds its last value.
- SETUP:
  - `csn`=0, `wen`=`oen`=1, `address` = captured address.
  - For writes, `data` is driven with the write data. For reads, `data` is high-Z.
  - Lasts `setup_cycles`.
- STROBE:
  - Write: `wen`=0, `oen`=1, `data` driven.
  - Read: `oen`=0, `wen`=1, `data` high-Z.
  - Lasts `strobe_cycles`.
  - Read data is sampled from `data` on the edge that ends the last STROBE cycle.
- HOLD: exactly 1 cycle. `wen`=`oen`=1, `csn`=0, address held, write data still driven.
- After HOLD the block returns to IDLE.
  - `rsp_valid`=1 for that first IDLE cycle.
  - `rsp_rdata` = the sampled value for a read, 0 for a write.
  - `req_ready` is also 1 in that cycle.
- Invariant: `wen` and `oen` are never low together.
- Invariant: `data` is never driven while `oen`=0.
- Cycle counter: $clog2 of max(`setup_cycles`, `strobe_cycles`)+1 bits. Loaded with count−1 on state entry; the state exits when the counter reaches 0.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `address`=0, `csn`=`wen`=`oen`=1, `data` high-Z, state IDLE.
- Reset mid-access: on the reset edge all strobes return high and `data` goes high-Z. The access is dropped and no `rsp_valid` is produced.
- Latency (no turnaround): accepted at edge E → `rsp_valid` high in cycle E+`setup_cycles`+`strobe_cycles`+1. With the defaults this is E+4.
- Throughput: the next request can be accepted on the edge ending the `rsp_valid` cycle. Back-to-back same-direction accesses take `setup_cycles`+`strobe_cycles`+2 cycles each; defaults give 5.
- `csn` rises in the cycle after HOLD. It is not held low across back-to-back accesses.

## Configuration
- `SRAM_MASTER_TURNAROUND_EN` defined:
  - When an accepted request's direction differs from the previous completed access, the block enters TURN for 1 cycle before SETUP.
  - TURN drives all strobes high and `data` high-Z.
  - Latency grows by 1 cycle in that case.
  - The first access after reset is treated as following a read.
- Not defined: TURN is absent; SETUP follows acceptance directly.

## Structure
- Shared package `sram_bus_pkg`:
  - state enum `sram_state_t` (IDLE, TURN, SETUP, STROBE, HOLD)
  - strobe-level constants `STROBE_ON`=0 and `STROBE_OFF`=1
- Single module. The tri-state driver is one continuous assign: `data` = write data when driving, else 'hz. No sub-module.

## Test plan
- Write 0xA5 to 0x123 with defaults → `csn` low for 4 cycles, `wen` low exactly cycles 2–3, `data`=0xA5 for 4 cycles, `rsp_valid` at E+4, `rsp_rdata`=0.
- Read back 0x123 from an attached SRAM model → `oen` low 2 cycles, `data` high-Z from the master, `rsp_rdata`=0xA5 at E+4.
- Back-to-back writes to 0x000 and 0x7FF with `req_valid` held high → accepts 5 cycles apart, `csn` high 1 cycle between accesses.
- Assert `rst` in the second STROBE cycle of a write → next cycle strobes=1, `data` Z, `req_ready`=1, no `rsp_valid` ever.
- With `SRAM_MASTER_TURNAROUND_EN`: write then read → read `rsp_valid` 5 cycles after its accept; read then read → 4 cycles.
- `setup_cycles`=3, `strobe_cycles`=1: read → `oen` low 1 cycle, `rsp_valid` at E+5; check `wen`/`oen` never both low throughout.
